led_chaser: RTL
===============

// Module: led_chaser
// PURPOSE
//  Parametrised multi-mode running-light ("water LED") driver for N_LED outputs.
//  Timing is a programmable step prescaler; four patterns are selectable at run time; a pause input freezes it.
//  Sits directly at the board LED pins, driven from the 100 MHz system clock.
// PARAMETERS
//  N_LED        4           number of LEDs, >= 2
//  STEP_CYCLES  50_000_000  clock cycles per pattern step (0.5 s @ 100 MHz), >= 2
//  PWM_BITS     4           PWM counter width (used only with LED_CHASER_PWM_EN)
// PORTS
//  clock      in   1         system clock, rising edge
//  reset      in   1         synchronous, active-high reset
//  mode       in   2         0 rotate-left, 1 rotate-right, 2 ping-pong, 3 bar-fill
//  pause      in   1         1 = freeze prescaler and pattern
//  pwm_duty   in   PWM_BITS  brightness (present only with LED_CHASER_PWM_EN)
//  step_tick  out  1         one-cycle pulse on each pattern step
//  led_out    out  N_LED     registered LED drive, 1 = lit
// BEHAVIOUR
//  Reset (reset=1 at a clock edge): prescaler=0, pattern=1 (bit0 only), dir=up, mode_q=mode,
//   step_tick=0, led_out=1. Reset mid-operation acts the same way on the next edge.
//  Prescaler counts 0..STEP_CYCLES-1 and wraps. step_tick=1 in the cycle the count is STEP_CYCLES-1
//   and pause=0. pause=1 holds the count and forces step_tick=0.
//  Pattern updates on the edge that ends a step_tick cycle. led_out follows the pattern
//   register directly (no extra latency).
//  mode 0: rotate left, MSB wraps to bit0 (0001,0010,0100,1000,0001...).
//  mode 1: rotate right, bit0 wraps to MSB (0001,1000,0100,0010,0001...).
//  mode 2: ping-pong, single lit bit. dir flips at the ends with no repeated end state
//   (0001,0010,0100,1000,0100,0010,0001,0010...).
//  mode 3: bar-fill. pattern = (pattern<<1)|1 until all ones, then all zero, then 0001...
//   (0001,0011,0111,1111,0000,0001...).
//  Mode change: mode is sampled into mode_q each cycle. When mode != mode_q, the next edge
//   reloads pattern=1, dir=up and prescaler=0, even if pause=1 or the cycle has a tick.
//   Reset has priority over the mode-change reload.
//  pause and a mode change in the same cycle: the reload happens and the pattern then stays frozen.
//  Prescaler width is $clog2(STEP_CYCLES). There are no illegal modes. Any non-one-hot state in
//   modes 0-2 (possible only after a mode switch from mode 3) is cleared by the reload.
// CONFIGURATION
//  LED_CHASER_PWM_EN defined: a free-running PWM_BITS counter is added (wraps, cleared by reset).
//   led_out = pattern & {N_LED{pwm_cnt < pwm_duty}}, registered, so led_out lags the pattern by 1 cycle.
//   pwm_duty=0 -> all LEDs off. The pwm_duty port exists only in this build.
//  Not defined: no PWM logic and no pwm_duty port. led_out = pattern at full brightness.
// STRUCTURE
//  led_chaser_defs.vh: `define mode codes (MODE_ROL=2'd0, MODE_ROR=2'd1, MODE_PING=2'd2,
//   MODE_FILL=2'd3) and the reset pattern constant. This file is shared with the bench.
//  Sub-module led_step_timer (params STEP_CYCLES; ports clock, reset, clr, hold, tick).
//   It holds the prescaler and is reused by later timing blocks.
//  Top level: mode_q register, pattern/dir next-state logic, optional PWM stage.
// TESTING (N_LED=4, STEP_CYCLES=10, PWM_BITS=4, 10 ns clock)
//  1 reset=1 for 5 cycles, then 0, mode=0 -> led_out=0001. step_tick every 10 cycles.
//    led_out runs 0010,0100,1000,0001.
//  2 mode=2 from reset, 8 ticks -> led_out runs 0010,0100,1000,0100,0010,0001,0010,0100.
//  3 mode=3, 6 ticks -> led_out runs 0011,0111,1111,0000,0001,0011.
//  4 mode=0, pause=1 for 35 cycles mid-step -> no step_tick, led_out constant.
//    After release, the next tick comes after the remaining count.
//  5 mode 0->1 while led_out=0100 -> 2 cycles later led_out=0001, prescaler=0.
//    First tick 10 cycles later gives 1000. Then reset=1 mid-step -> led_out=0001 next edge.
//  6 [PWM_EN] pwm_duty=4, led_out pattern 0001 -> bit0 high 4 of every 16 cycles.
//    pwm_duty=0 -> led_out=0000 constantly.

Source files
------------

// File: rtl/led_chaser_pkg.sv
// Shared definitions for the LED chaser slice.
//  mode_e : run-time pattern selection (rotate-left, rotate-right, ping-pong, bar-fill)
//  dir_e  : sweep direction of the ping-pong pattern
//  prescale_width() : counter width for a step prescaler of a given length
// The bench imports this package too, so mode codes live in one place.
package led_chaser_pkg;

    typedef enum logic [1:0] {
        MODE_ROL  = 2'd0,
        MODE_ROR  = 2'd1,
        MODE_PING = 2'd2,
        MODE_FILL = 2'd3
    } mode_e;

    typedef enum logic {
        DIR_UP   = 1'b0,
        DIR_DOWN = 1'b1
    } dir_e;

    // Bit index lit by the reset / reload pattern.
    localparam int RESET_LED = 0;

    // $clog2 of the step length, never narrower than one bit.
    function automatic int prescale_width(input int cycles);
        return (cycles <= 2) ? 1 : $clog2(cycles);
    endfunction

endpackage

// File: rtl/led_chaser_if.sv
// Control/status bundle between a controller and the LED chaser.
//  mode      2        pattern select (see mode_e)
//  pause     1        freeze prescaler and pattern
//  pwm_duty  PWM_BITS brightness, only when LED_CHASER_PWM_EN is defined
//  step_tick 1        one-cycle pulse per pattern step
//  led_out   N_LED    LED drive, 1 = lit
// master drives the controls, slave (the chaser) drives the status.
interface led_chaser_if #(
    parameter int N_LED = 4
`ifdef LED_CHASER_PWM_EN
    , parameter int PWM_BITS = 4
`endif
);
    logic [1:0]       mode;
    logic             pause;
`ifdef LED_CHASER_PWM_EN
    logic [PWM_BITS-1:0] pwm_duty;
`endif
    logic             step_tick;
    logic [N_LED-1:0] led_out;

`ifdef LED_CHASER_PWM_EN
    modport master (output mode, pause, pwm_duty, input step_tick, led_out);
    modport slave  (input mode, pause, pwm_duty, output step_tick, led_out);
`else
    modport master (output mode, pause, input step_tick, led_out);
    modport slave  (input mode, pause, output step_tick, led_out);
`endif
endinterface

// File: rtl/led_step_timer.sv
// Step prescaler: counts 0..STEP_CYCLES-1 and wraps.
//  clock in  system clock
//  reset in  synchronous active-high reset (count -> 0)
//  clr   in  restart the step (count -> 0), wins over hold
//  hold  in  freeze the count; also masks tick
//  tick  out high while the count sits on its last value and hold=0
module led_step_timer
    import led_chaser_pkg::*;
#(
    parameter int STEP_CYCLES = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic hold,
    output logic tick
);
    localparam int           CW   = prescale_width(STEP_CYCLES);
    localparam logic [CW-1:0] LAST = CW'(STEP_CYCLES - 1);

    logic [CW-1:0] cnt_reg;
    logic [CW-1:0] cnt_next;

    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (!hold) begin
            cnt_next = (cnt_reg == LAST) ? '0 : cnt_reg + 1'b1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

    assign tick = (cnt_reg == LAST) && !hold;

endmodule

// File: rtl/led_chaser.sv
// Multi-mode running-light driver for N_LED board LEDs.
//  clock in  system clock, rising edge
//  reset in  synchronous active-high reset
//  bus   led_chaser_if.slave: mode, pause, [pwm_duty] in; step_tick, led_out out
// Optional build macro LED_CHASER_PWM_EN adds a free-running PWM dimmer; led_out
// is then registered once more and lags the pattern by one cycle.
module led_chaser
    import led_chaser_pkg::*;
#(
    parameter int N_LED       = 4,
    parameter int STEP_CYCLES = 50_000_000,
    parameter int PWM_BITS    = 4
) (
    input  logic        clock,
    input  logic        reset,
    led_chaser_if.slave bus
);
    if (N_LED < 2 || STEP_CYCLES < 2 || PWM_BITS < 1) begin : g_bad_params
        $error("led_chaser: parameter out of range");
    end

    localparam logic [N_LED-1:0] PAT_RESET = N_LED'(1) << RESET_LED;

    mode_e            mode_q_reg;
    dir_e             dir_reg, dir_next;
    logic [N_LED-1:0] pattern_reg, pattern_next;
    logic             mode_change;
    logic             tick;

    assign mode_change = (mode_e'(bus.mode) != mode_q_reg);

    // A mode change restarts the step so the new pattern gets a full first step.
    led_step_timer #(.STEP_CYCLES(STEP_CYCLES)) u_timer (
        .clock (clock),
        .reset (reset),
        .clr   (mode_change),
        .hold  (bus.pause),
        .tick  (tick)
    );

    assign bus.step_tick = tick;

    always_ff @(posedge clock) begin
        if (reset) begin
            mode_q_reg  <= mode_e'(bus.mode);
            dir_reg     <= DIR_UP;
            pattern_reg <= PAT_RESET;
        end else begin
            mode_q_reg  <= mode_e'(bus.mode);
            dir_reg     <= dir_next;
            pattern_reg <= pattern_next;
        end
    end

    always_comb begin
        dir_next     = dir_reg;
        pattern_next = pattern_reg;
        if (mode_change) begin
            // Reload also scrubs any multi-bit state left over from bar-fill.
            dir_next     = DIR_UP;
            pattern_next = PAT_RESET;
        end else if (tick) begin
            unique case (mode_q_reg)
                MODE_ROL:  pattern_next = {pattern_reg[N_LED-2:0], pattern_reg[N_LED-1]};
                MODE_ROR:  pattern_next = {pattern_reg[0], pattern_reg[N_LED-1:1]};
                MODE_PING: begin
                    // Turn around at an end without repeating the end state.
                    if (dir_reg == DIR_UP) begin
                        if (pattern_reg[N_LED-1]) begin
                            dir_next     = DIR_DOWN;
                            pattern_next = pattern_reg >> 1;
                        end else begin
                            pattern_next = pattern_reg << 1;
                        end
                    end else begin
                        if (pattern_reg[0]) begin
                            dir_next     = DIR_UP;
                            pattern_next = pattern_reg << 1;
                        end else begin
                            pattern_next = pattern_reg >> 1;
                        end
                    end
                end
                MODE_FILL: pattern_next = (&pattern_reg) ? '0 : {pattern_reg[N_LED-2:0], 1'b1};
                default:   pattern_next = PAT_RESET;
            endcase
        end
    end

`ifdef LED_CHASER_PWM_EN
    logic [PWM_BITS-1:0] pwm_cnt_reg;
    logic [N_LED-1:0]    led_pwm;
    logic [N_LED-1:0]    led_out_reg;
    logic                pwm_on;

    assign pwm_on = (pwm_cnt_reg < bus.pwm_duty);

    for (genvar gi = 0; gi < N_LED; gi++) begin : g_pwm_bit
        assign led_pwm[gi] = pattern_reg[gi] & pwm_on;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            pwm_cnt_reg <= '0;
            led_out_reg <= PAT_RESET;
        end else begin
            pwm_cnt_reg <= pwm_cnt_reg + 1'b1;
            led_out_reg <= led_pwm;
        end
    end

    assign bus.led_out = led_out_reg;
`else
    assign bus.led_out = pattern_reg;
`endif

endmodule
